// File: rtl/lcd_hd44780_drv_if.sv
// Register-side bus of the HD44780 LCD driver.
// The core's memory-mapped LCD register (lsu io_lcd_o) comes in on io_lcd_i,
// and busy/overrun go back to the core for a status read.
//   io_lcd_i   32  [31]=ON, [11]=overrun clear, [10]=request toggle, [9]=RS, [7:0]=DATA
//   busy_o      1  transfer or init sequence in progress
//   overrun_o   1  sticky, set when a request arrives while busy
// Modports: master = core/testbench side, slave = driver side.
interface lcd_hd44780_drv_if;
    logic [31:0] io_lcd_i;
    logic        busy_o;
    logic        overrun_o;

    modport master (output io_lcd_i, input busy_o, input overrun_o);
    modport slave  (input io_lcd_i, output busy_o, output overrun_o);
endinterface

// File: rtl/lcd_hd44780_drv.sv
// HD44780 LCD bus driver.
// Converts toggle-bit write requests from the core's LCD register into
// HD44780 write cycles: RS/DATA setup, EN pulse, hold, then the execution wait
// the controller needs before it accepts the next command.
// Ports:
//   clk_i       clock
//   rst_ni      synchronous active-low reset
//   bus         lcd_hd44780_drv_if.slave (io_lcd_i in, busy_o/overrun_o out)
//   lcd_on_o    LCD power/backlight enable (registered copy of io_lcd_i[31])
//   lcd_en_o    HD44780 EN
//   lcd_rs_o    HD44780 RS
//   lcd_rw_o    HD44780 RW, tied low (write-only interface)
//   lcd_data_o  HD44780 DB[7:0]
// Build option: define LCD_INIT_SEQ_EN to run the power-up wait and the
// 0x38/0x0C/0x01/0x06 init sequence in hardware after reset or abort.
module lcd_hd44780_drv #(
    parameter int T_SETUP_CYC   = 2,
    parameter int T_EN_HIGH_CYC = 25,
    parameter int T_HOLD_CYC    = 2,
    parameter int T_EXEC_CYC    = 2500,
    parameter int T_CLEAR_CYC   = 82000,
    parameter int T_PWRUP_CYC   = 750000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    lcd_hd44780_drv_if.slave        bus,
    output logic                    lcd_on_o,
    output logic                    lcd_en_o,
    output logic                    lcd_rs_o,
    output logic                    lcd_rw_o,
    output logic [7:0]              lcd_data_o
);

    localparam int MAX_A   = (T_SETUP_CYC > T_EN_HIGH_CYC) ? T_SETUP_CYC : T_EN_HIGH_CYC;
    localparam int MAX_B   = (T_HOLD_CYC > T_EXEC_CYC) ? T_HOLD_CYC : T_EXEC_CYC;
    localparam int MAX_C   = (T_CLEAR_CYC > T_PWRUP_CYC) ? T_CLEAR_CYC : T_PWRUP_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CW      = $clog2(MAX_CYC + 1);

    // Counter reload values: a phase lasting N cycles counts N-1 down to 0.
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] SETUP_LD = CW'(T_SETUP_CYC - 1);
    localparam logic [CW-1:0] EN_LD    = CW'(T_EN_HIGH_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(T_HOLD_CYC - 1);
    localparam logic [CW-1:0] EXEC_LD  = CW'(T_EXEC_CYC - 1);
    localparam logic [CW-1:0] CLEAR_LD = CW'(T_CLEAR_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
    localparam logic [CW-1:0] PWRUP_LD = CW'(T_PWRUP_CYC - 1);
`endif

    typedef enum logic [2:0] {
        ST_PWRUP = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4,
        ST_EXEC  = 3'd5
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            req_r;       // previous value of the request toggle bit
    logic            busy_r;
    logic            overrun_r;
    logic            on_r;
    logic            en_r;
    logic            rs_r;
    logic [7:0]      data_r;
`ifdef LCD_INIT_SEQ_EN
    logic            init_run_r;
    logic [1:0]      init_idx_r;
`endif

    logic            req_s;
    logic            abort_s;
    logic            unused_s;

    // Clear/return-home commands need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
        return (rs == 1'b0) && ((d == 8'h01) || (d == 8'h02) || (d == 8'h03));
    endfunction

`ifdef LCD_INIT_SEQ_EN
    // Init sequence: 8-bit 2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction
`endif

    // Either edge of the toggle bit is one request.
    assign req_s    = bus.io_lcd_i[10] ^ req_r;
    // Dropping ON kills a transfer in flight; the power-up wait is left alone.
    assign abort_s  = !bus.io_lcd_i[31] && (state_r != ST_IDLE) && (state_r != ST_PWRUP);
    assign unused_s = ^{bus.io_lcd_i[30:12], bus.io_lcd_i[8]};

    assign bus.busy_o    = busy_r;
    assign bus.overrun_o = overrun_r;
    assign lcd_on_o      = on_r;
    assign lcd_en_o      = en_r;
    assign lcd_rs_o      = rs_r;
    assign lcd_rw_o      = 1'b0;
    assign lcd_data_o    = data_r;

    // Transfer FSM with phase counter, request edge detect and sticky overrun.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            req_r     <= 1'b0;
            on_r      <= 1'b0;
            en_r      <= 1'b0;
            rs_r      <= 1'b0;
            data_r    <= 8'h00;
            overrun_r <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            state_r    <= ST_PWRUP;
            busy_r     <= 1'b1;
            cnt_r      <= PWRUP_LD;
            init_run_r <= 1'b0;
            init_idx_r <= 2'd0;
`else
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            cnt_r     <= CNT_ZERO;
`endif
        end else begin
            req_r <= bus.io_lcd_i[10];
            on_r  <= bus.io_lcd_i[31];

            // A request that arrives in the same cycle as a clear still sets.
            if (req_s && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end else if (bus.io_lcd_i[11]) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end

            if (abort_s) begin
                en_r   <= 1'b0;
                rs_r   <= 1'b0;
                data_r <= 8'h00;
`ifdef LCD_INIT_SEQ_EN
                state_r    <= ST_PWRUP;
                busy_r     <= 1'b1;
                cnt_r      <= PWRUP_LD;
                init_run_r <= 1'b0;
                init_idx_r <= 2'd0;
`else
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                cnt_r   <= CNT_ZERO;
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (req_s && bus.io_lcd_i[31]) begin
                            rs_r    <= bus.io_lcd_i[9];
                            data_r  <= bus.io_lcd_i[7:0];
                            busy_r  <= 1'b1;
                            cnt_r   <= SETUP_LD;
                            state_r <= ST_SETUP;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_SETUP: begin
                        if (cnt_r == CNT_ZERO) begin
                            en_r    <= 1'b1;
                            cnt_r   <= EN_LD;
                            state_r <= ST_PULSE;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_r == CNT_ZERO) begin
                            en_r    <= 1'b0;
                            cnt_r   <= HOLD_LD;
                            state_r <= ST_HOLD;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_HOLD: begin
                        if (cnt_r == CNT_ZERO) begin
                            cnt_r   <= is_slow_cmd(rs_r, data_r) ? CLEAR_LD : EXEC_LD;
                            state_r <= ST_EXEC;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
                    end
                    ST_EXEC: begin
                        if (cnt_r != CNT_ZERO) begin
                            cnt_r <= cnt_r - CNT_ONE;
`ifdef LCD_INIT_SEQ_EN
                        end else if (init_run_r && (init_idx_r != 2'd3)) begin
                            init_idx_r <= init_idx_r + 2'd1;
                            rs_r       <= 1'b0;
                            data_r     <= init_cmd(init_idx_r + 2'd1);
                            cnt_r      <= SETUP_LD;
                            state_r    <= ST_SETUP;
`endif
                        end else begin
`ifdef LCD_INIT_SEQ_EN
                            init_run_r <= 1'b0;
`endif
                            rs_r    <= 1'b0;
                            data_r  <= 8'h00;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_PWRUP: begin
`ifdef LCD_INIT_SEQ_EN
                        if (cnt_r == CNT_ZERO) begin
                            init_run_r <= 1'b1;
                            init_idx_r <= 2'd0;
                            rs_r       <= 1'b0;
                            data_r     <= init_cmd(2'd0);
                            cnt_r      <= SETUP_LD;
                            state_r    <= ST_SETUP;
                        end else begin
                            cnt_r <= cnt_r - CNT_ONE;
                        end
`else
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
`endif
                    end
                    default: begin
                        en_r    <= 1'b0;
                        rs_r    <= 1'b0;
                        data_r  <= 8'h00;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lcd_hd44780_drv.sv
// Self-checking bench for lcd_hd44780_drv with shortened timing parameters.
// The reference model describes each transfer as a timeline: busy for
// setup+en+hold+exec cycles after the request, EN high during the middle window,
// RS/DATA presented while busy, and zero otherwise.
module tb_lcd_hd44780_drv;

    localparam int T_SETUP = 2;
    localparam int T_EN    = 4;
    localparam int T_HOLD  = 2;
    localparam int T_EXEC  = 10;
    localparam int T_CLEAR = 30;
    localparam int T_PWRUP = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_on;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    int checks = 0;
    int failures = 0;

    logic       cur_on = 1'b1;
    logic       cur_clr = 1'b0;
    logic       cur_rs = 1'b0;
    logic [7:0] cur_data = 8'h00;
    logic       tog = 1'b0;

    lcd_hd44780_drv_if bus();

    lcd_hd44780_drv #(
        .T_SETUP_CYC   (T_SETUP),
        .T_EN_HIGH_CYC (T_EN),
        .T_HOLD_CYC    (T_HOLD),
        .T_EXEC_CYC    (T_EXEC),
        .T_CLEAR_CYC   (T_CLEAR),
        .T_PWRUP_CYC   (T_PWRUP)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .lcd_on_o   (lcd_on),
        .lcd_en_o   (lcd_en),
        .lcd_rs_o   (lcd_rs),
        .lcd_rw_o   (lcd_rw),
        .lcd_data_o (lcd_data)
    );

    always #5 clk = ~clk;

    // Reference model: total busy time of one request.
    function automatic int busy_len(input logic rs, input logic [7:0] d);
        int ex;
        ex = (!rs && d >= 8'd1 && d <= 8'd3) ? T_CLEAR : T_EXEC;
        return T_SETUP + T_EN + T_HOLD + ex;
    endfunction

    // Reference model: expected {busy,overrun,on,en,rs,rw,data} k cycles after a request.
    function automatic logic [13:0] expect_vec(input int k, input int n, input logic rs,
                                               input logic [7:0] d, input logic ovr);
        logic b;
        logic e;
        b = (k >= 1 && k <= n);
        e = (k >= T_SETUP + 1 && k <= T_SETUP + T_EN);
        return {b, ovr, 1'b1, e, b ? rs : 1'b0, 1'b0, b ? d : 8'h00};
    endfunction

    function automatic logic [13:0] got_vec();
        return {bus.busy_o, bus.overrun_o, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data};
    endfunction

    task automatic apply();
        logic [18:0] junk;
        junk = 19'($urandom);
        bus.io_lcd_i = {cur_on, junk, cur_clr, tog, cur_rs, 1'($urandom), cur_data};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic rs, input logic [7:0] d);
        cur_rs = rs;
        cur_data = d;
        tog = ~tog;
        apply();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tog = 1'b0;
        cur_on = 1'b1;
        apply();
        repeat (3) step();
        checks++;
`ifdef LCD_INIT_SEQ_EN
        if (got_vec() !== 14'b10_0000_0000_0000) begin
`else
        if (got_vec() !== 14'd0) begin
`endif
            failures++;
            $display("FAIL reset_outputs got=%b", got_vec());
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (lcd_on !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_on got=%b want=1", lcd_on);
        end
`ifdef LCD_INIT_SEQ_EN
        begin
            logic [7:0] caught[$];
            logic [7:0] want[4];
            logic       prev_en;
            int         fall_k;
            int         init_total;
            want = '{8'h38, 8'h0C, 8'h01, 8'h06};
            init_total = T_PWRUP;
            foreach (want[i]) init_total += busy_len(1'b0, want[i]);
            prev_en = 1'b0;
            fall_k = -1;
            for (int k = 2; k <= init_total + 20; k++) begin
                if (lcd_en && !prev_en) caught.push_back(lcd_data);
                prev_en = lcd_en;
                if (fall_k < 0 && !bus.busy_o) fall_k = k - 1;
                step();
            end
            checks++;
            if (fall_k !== init_total) begin
                failures++;
                $display("FAIL init_busy_fall got=%0d want=%0d", fall_k, init_total);
            end
            checks++;
            if (caught.size() != 4) begin
                failures++;
                $display("FAIL init_pulse_count got=%0d want=4", caught.size());
            end else begin
                foreach (want[i]) begin
                    checks++;
                    if (caught[i] !== want[i]) begin
                        failures++;
                        $display("FAIL init_cmd%0d got=%h want=%h", i, caught[i], want[i]);
                    end
                end
            end
        end
`else
        checks++;
        if (bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b want=0", bus.busy_o);
        end
`endif
    endtask

    task automatic test_transfer(input logic rs, input logic [7:0] d);
        int n;
        n = busy_len(rs, d);
        issue(rs, d);
        for (int k = 1; k <= n + 3; k++) begin
            step();
            checks++;
            if (got_vec() !== expect_vec(k, n, rs, d, 1'b0)) begin
                failures++;
                $display("FAIL transfer rs=%0b d=%h k=%0d got=%b want=%b",
                         rs, d, k, got_vec(), expect_vec(k, n, rs, d, 1'b0));
            end
        end
    endtask

    task automatic test_exec_length();
        test_transfer(1'b0, 8'h01);
        test_transfer(1'b1, 8'h01);
        test_transfer(1'b0, 8'h02);
        test_transfer(1'b0, 8'h03);
        test_transfer(1'b0, 8'h00);
        test_transfer(1'b0, 8'h04);
    endtask

    task automatic test_random();
        logic       rs;
        logic [7:0] d;
        for (int i = 0; i < 10; i++) begin
            rs = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
            test_transfer(rs, d);
        end
    endtask

    task automatic test_overrun();
        int  n;
        logic ovr;
        n = busy_len(1'b1, 8'h55);
        issue(1'b1, 8'h55);
        for (int k = 1; k <= n + 25; k++) begin
            step();
            ovr = (k >= 6 && k <= n + 5);
            checks++;
            if (got_vec() !== expect_vec(k, n, 1'b1, 8'h55, ovr)) begin
                failures++;
                $display("FAIL overrun k=%0d got=%b want=%b",
                         k, got_vec(), expect_vec(k, n, 1'b1, 8'h55, ovr));
            end
            if (k == 5) begin
                issue(1'b0, 8'h99);
            end else if (k == 10) begin
                cur_clr = 1'b1;
                issue(1'b1, 8'hA5);
            end else if (k == 11 || k == n + 6) begin
                cur_clr = 1'b0;
                apply();
            end else if (k == n + 5) begin
                cur_clr = 1'b1;
                apply();
            end
        end
    endtask

    task automatic test_abort();
        int n;
        n = busy_len(1'b1, 8'h41);
        issue(1'b1, 8'h41);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (got_vec() !== expect_vec(k, n, 1'b1, 8'h41, 1'b0)) begin
                failures++;
                $display("FAIL abort_pre k=%0d got=%b want=%b",
                         k, got_vec(), expect_vec(k, n, 1'b1, 8'h41, 1'b0));
            end
        end
        cur_on = 1'b0;
        apply();
        step();
        checks++;
        if (got_vec() !== 14'd0) begin
            failures++;
            $display("FAIL abort_edge got=%b want=0", got_vec());
        end
        issue(1'b1, 8'h42);
        for (int k = 0; k < 25; k++) begin
            step();
            checks++;
            if (got_vec() !== 14'd0) begin
                failures++;
                $display("FAIL abort_off_toggle k=%0d got=%b want=0", k, got_vec());
            end
        end
        cur_on = 1'b1;
        apply();
        step();
        checks++;
        if ({lcd_on, bus.busy_o, lcd_en} !== 3'b100) begin
            failures++;
            $display("FAIL abort_reon got=%b want=100", {lcd_on, bus.busy_o, lcd_en});
        end
    endtask

    task automatic test_reset_midway();
        int n;
        n = busy_len(1'b0, 8'h02);
        issue(1'b0, 8'h02);
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (got_vec() !== expect_vec(k, n, 1'b0, 8'h02, 1'b0)) begin
                failures++;
                $display("FAIL rstmid_pre k=%0d got=%b want=%b",
                         k, got_vec(), expect_vec(k, n, 1'b0, 8'h02, 1'b0));
            end
        end
        rst_n = 1'b0;
        tog = 1'b0;
        apply();
        step();
        checks++;
        if (got_vec() !== 14'd0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b want=0", got_vec());
        end
        rst_n = 1'b1;
        step();
        checks++;
        if ({lcd_on, bus.busy_o, lcd_en} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_release got=%b want=100", {lcd_on, bus.busy_o, lcd_en});
        end
        test_transfer(1'b1, 8'h33);
    endtask

    initial begin
        bus.io_lcd_i = 32'd0;
        test_reset();
        test_transfer(1'b1, 8'h41);
`ifndef LCD_INIT_SEQ_EN
        test_exec_length();
        test_random();
        test_overrun();
        test_abort();
        test_reset_midway();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
